// File: rtl/spi_arb.sv
// ---------------------------------------------------------------------------
// spi_arb -- two-requester ownership arbiter in front of one shared SPI_mnrch.
//
// Requester 0 (A2D sequencer) and requester 1 (inertial sensor) each raise
// reqX for a whole multi-transaction frame. Once granted, the owner's start
// pulse and command word pass straight through to the SPI monarch, and the
// monarch's done pulse is routed back to the owner only. An owner that sits
// idle (no wrt) for TIMEOUT owned cycles loses the grant and err pulses.
// Ties go to the requester that was not granted last.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   req0, req1          ownership requests
//   gnt0, gnt1          ownership grants (registered, at most one high)
//   wrt0, wrt1          requester start-transaction pulses
//   wt_data0, wt_data1  requester command words
//   done0, done1        per-requester transaction-complete pulses
//   wrt, wt_data        start pulse / command word to the SPI monarch
//   done                completion pulse from the SPI monarch
//   busy                registered, high while a requester owns the bus
//   err                 one-cycle pulse on a timeout revoke
//
// Grant timing: gnt/busy rise one cycle after the FSM enters OWN, and fall in
// the same cycle the FSM re-enters IDLE, so a waiting requester sees its grant
// two cycles after the previous owner's grant falls.
// ---------------------------------------------------------------------------
module spi_arb #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        wrt0,
  input  logic        wrt1,
  input  logic [15:0] wt_data0,
  input  logic [15:0] wt_data1,
  output logic        done0,
  output logic        done1,
  output logic        wrt,
  output logic [15:0] wt_data,
  input  logic        done,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;

  logic        own_req;
  logic        own_wrt;
  logic [15:0] own_data;
  logic        pick;
  logic        cnt_at_last;
  logic        rel_own;
  logic        keep;
  logic        revoke;

  // Owner-side views of the requester inputs; the non-owner is never looked at.
  assign own_req  = owner ? req1 : req0;
  assign own_wrt  = owner ? wrt1 : wrt0;
  assign own_data = owner ? wt_data1 : wt_data0;

  // Winner when leaving IDLE: a lone requester wins, a tie goes to ~last.
  assign pick = (req0 && req1) ? ~last : req1;

  assign cnt_at_last = (cnt == CNT_LAST);

  // An owner wrt always wins over a release in the same cycle, so a
  // transfer that was started is never dropped by req falling.
  assign rel_own = (state == OWN) && !own_wrt && (!own_req || cnt_at_last);
  assign revoke  = (state == OWN) && !own_wrt && own_req && cnt_at_last;

  // Ownership continues into the next cycle (drives the registered grant).
  assign keep = (state == XFER) || ((state == OWN) && !rel_own);

  // Pass-through paths to/from the SPI monarch, gated by state and owner.
  assign wrt     = (state == OWN) && own_wrt;
  assign wt_data = (state == OWN) ? own_data : 16'h0000;
  assign done0   = (state == XFER) && !owner && done;
  assign done1   = (state == XFER) && owner && done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      gnt0 <= keep && !owner;
      gnt1 <= keep && owner;
      busy <= keep;
      err  <= revoke;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= pick;
            last  <= pick;
            cnt   <= '0;
            state <= OWN;
          end
        end

        OWN: begin
          if (own_wrt) begin
            cnt   <= '0;
            state <= XFER;
          end else if (!own_req || cnt_at_last) begin
            // Release or timeout revoke; last keeps this owner so the other
            // requester wins the next tie.
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          // The counter is frozen here; it restarts on the return to OWN.
          if (done) begin
            cnt   <= '0;
            state <= OWN;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// ---------------------------------------------------------------------------
// tb_spi_arb -- self-checking bench for spi_arb (TIMEOUT = 8).
// Each row is one clock cycle: inputs are applied 1 ns after the rising edge,
// the expected outputs are queued, and 1 ns later the queue head is popped and
// compared against the DUT outputs for that same cycle.
// ---------------------------------------------------------------------------
module tb_spi_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic        gnt0, gnt1;
  logic        wrt0, wrt1;
  logic [15:0] wt_data0, wt_data1;
  logic        done0, done1;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [15:0] d0, d1;
    logic        dn;
    logic        g0, g1, bsy, er, wr;
    logic [15:0] wd;
    logic        dn0, dn1;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_c[$];
  vec_t sb_q[$];

  spi_arb #(.TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .wrt0     (wrt0),
    .wrt1     (wrt1),
    .wt_data0 (wt_data0),
    .wt_data1 (wt_data1),
    .done0    (done0),
    .done1    (done1),
    .wrt      (wrt),
    .wt_data  (wt_data),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit r0, bit r1, bit w0, bit w1,
                              logic [15:0] d0, logic [15:0] d1, bit dn,
                              bit g0, bit g1, bit bsy, bit er, bit wr,
                              logic [15:0] wd, bit dn0, bit dn1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.d0 = d0; v.d1 = d1; v.dn = dn;
    v.g0 = g0; v.g1 = g1; v.bsy = bsy; v.er = er; v.wr = wr;
    v.wd = wd; v.dn0 = dn0; v.dn1 = dn1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".gnt0"},    {15'd0, gnt0},  {15'd0, e.g0});
    chk({tag, ".gnt1"},    {15'd0, gnt1},  {15'd0, e.g1});
    chk({tag, ".busy"},    {15'd0, busy},  {15'd0, e.bsy});
    chk({tag, ".err"},     {15'd0, err},   {15'd0, e.er});
    chk({tag, ".wrt"},     {15'd0, wrt},   {15'd0, e.wr});
    chk({tag, ".wt_data"}, wt_data,        e.wd);
    chk({tag, ".done0"},   {15'd0, done0}, {15'd0, e.dn0});
    chk({tag, ".done1"},   {15'd0, done1}, {15'd0, e.dn1});
  endtask

  task automatic cyc(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    req0 = v.r0; req1 = v.r1; wrt0 = v.w0; wrt1 = v.w1;
    wt_data0 = v.d0; wt_data1 = v.d1; done = v.dn;
    sb_q.push_back(v);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard: queue empty, expected 1 entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_outs(tag, e);
    end
  endtask

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; wrt0 = 1'b0; wrt1 = 1'b0;
    wt_data0 = 16'h0000; wt_data1 = 16'h0000; done = 1'b0;
  endtask

  initial begin
    vec_t zero_v;
    zero_v = mk(0,0,0,0,16'h0,16'h0,0, 0,0,0,0,0,16'h0,0,0);

    //             r0 r1 w0 w1 d0       d1       dn  g0 g1 bsy er wr wd       dn0 dn1
    // Tie after reset grants 0; passthrough, non-owner ignored, XFER, release.
    tbl_a.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 0 IDLE
    tbl_a.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 1 OWN o0
    tbl_a.push_back(mk(1,1,0,1,16'h0000,16'h7FFF,0, 1,0,1,0,0,16'h0000,0,0)); // 2 wrt1 ignored
    tbl_a.push_back(mk(1,1,1,0,16'h2000,16'h0000,0, 1,0,1,0,1,16'h2000,0,0)); // 3 wrt0 passes
    tbl_a.push_back(mk(0,1,0,0,16'h1234,16'h0000,0, 1,0,1,0,0,16'h0000,0,0)); // 4 XFER, req0 drop
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,1, 1,0,1,0,0,16'h0000,1,0)); // 5 done -> done0
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,1, 1,0,1,0,0,16'h0000,0,0)); // 6 OWN, done ignored
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 7 IDLE, gnt0 fell
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 8 OWN o1 cnt0
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,1, 0,1,1,0,0,16'h0000,0,0)); // 9 gnt1 up, done ign
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 10 cnt2
    tbl_a.push_back(mk(0,1,1,0,16'hFFFF,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 11 wrt0 ignored
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0F0F,0, 0,1,1,0,0,16'h0F0F,0,0)); // 12 owner data
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 13 cnt5
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 14 cnt6
    tbl_a.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 15 cnt7 revoke
    tbl_a.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,1,0,16'h0000,0,0)); // 16 IDLE, err
    tbl_a.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 17 OWN o0
    tbl_a.push_back(mk(1,1,1,0,16'hABCD,16'h0000,0, 1,0,1,0,1,16'hABCD,0,0)); // 18 gnt0, wrt0
    tbl_a.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 1,0,1,0,0,16'h0000,0,0)); // 19 XFER

    // After reset: tie -> 0, wrt with req low in same cycle, then tie -> 1.
    tbl_c.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 0 IDLE
    tbl_c.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 1 OWN o0
    tbl_c.push_back(mk(0,1,1,0,16'h5555,16'h0000,0, 1,0,1,0,1,16'h5555,0,0)); // 2 wrt0 + req0 low
    tbl_c.push_back(mk(0,1,0,0,16'h0000,16'h0000,1, 1,0,1,0,0,16'h0000,1,0)); // 3 XFER done
    tbl_c.push_back(mk(0,1,0,0,16'h0000,16'h0000,0, 1,0,1,0,0,16'h0000,0,0)); // 4 OWN release
    tbl_c.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 5 IDLE tie
    tbl_c.push_back(mk(1,1,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 6 OWN o1
    tbl_c.push_back(mk(1,1,1,1,16'h1111,16'h3C3C,0, 0,1,1,0,1,16'h3C3C,0,0)); // 7 wrt1 passes
    tbl_c.push_back(mk(1,1,0,0,16'h0000,16'h0000,1, 0,1,1,0,0,16'h0000,0,1)); // 8 done -> done1
    tbl_c.push_back(mk(0,0,0,0,16'h0000,16'h0000,0, 0,1,1,0,0,16'h0000,0,0)); // 9 OWN release
    tbl_c.push_back(mk(0,0,0,0,16'h0000,16'h0000,0, 0,0,0,0,0,16'h0000,0,0)); // 10 IDLE

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", zero_v);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl_a[i]) cyc(tbl_a[i], $sformatf("a%0d", i));

    // Reset asserted mid-XFER; a later done must not reach either requester.
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; done = 1'b1;
    #1;
    check_outs("rst_xfer", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    done = 1'b0;
    cyc(mk(0,0,0,0,16'h0,16'h0,1, 0,0,0,0,0,16'h0,0,0), "post_rst0");
    cyc(mk(0,0,0,0,16'h0,16'h0,1, 0,0,0,0,0,16'h0,0,0), "post_rst1");

    // Fresh reset so the first tie again belongs to requester 0.
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl_c[i]) cyc(tbl_c[i], $sformatf("c%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter: TIMEOUT, default 1024, number of idle owned cycles (no wrt) before the grant is revoked.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester ownership request (0 = A2D sequencer, 1 = inertial sensor); held high for the whole multi-transaction frame.
REQ-005 gnt0, gnt1  output  1 each  ownership grant; at most one high.
REQ-006 wrt0, wrt1  input  1 each  requester start-transaction pulse.
REQ-007 wt_data0, wt_data1  input  16 each  requester command words.
REQ-008 done0, done1  output  1 each  per-requester transaction-complete pulse.
REQ-009 wrt  output  1  start pulse to the shared SPI_mnrch.
REQ-010 wt_data  output  16  command word to the shared SPI_mnrch.
REQ-011 done  input  1  completion pulse from the shared SPI_mnrch; rd_data is not routed by this block and fans out directly to both requesters.
REQ-012 busy  output  1  high whenever any requester owns the bus.
REQ-013 err  output  1  one-cycle pulse on a timeout revoke.

Function
REQ-014 FSM states: IDLE, OWN, XFER; a 1-bit owner register and a 1-bit last register (last owner granted).
REQ-015 IDLE: req0 only -> owner=0; req1 only -> owner=1; both -> owner=~last; next state OWN.
REQ-016 gnt and busy rise the cycle after the FSM leaves IDLE (1-cycle grant latency); gnt_owner is high in OWN and XFER, low in IDLE.
REQ-017 On grant, last shall be loaded with owner.
REQ-018 OWN: owner's wrt shall pass combinationally to wrt, and wt_data shall equal the owner's wt_data; next state XFER.
REQ-019 wrt and wt_data from the non-owner shall be ignored in every state; in IDLE and XFER, wrt=0 and wt_data=16'h0000.
REQ-020 OWN with the owner's req low and no owner wrt -> IDLE; gnt drops the next cycle.
REQ-021 XFER: done shall pass combinationally to done_owner only; the other done output stays 0; next state OWN.
REQ-022 A req drop during XFER shall not abort the transfer; the arbiter returns to OWN and then follows REQ-020.
REQ-023 A done arriving in IDLE or OWN shall be ignored (no doneX pulse).
REQ-024 Timeout counter: clears on entering OWN and on each owner wrt, increments each OWN cycle; it shall not count in XFER.
REQ-025 Counter at TIMEOUT-1 in OWN -> IDLE, err pulses for 1 cycle, gnt drops; the revoked owner remains recorded in last, so the other requester wins the next tie.
REQ-026 Counter width is $clog2(TIMEOUT) bits, with no wrap before the revoke.
REQ-027 Back-to-back requests: after a release, IDLE takes one cycle, so a waiting requester sees gnt 2 cycles after the previous owner's gnt falls.
REQ-028 Owner wrt and req-low in the same OWN cycle: the transfer starts (XFER), and the release follows REQ-022.

Reset
REQ-029 Reset shall asynchronously force state=IDLE, owner=0, last=1, counter=0, gnt0=gnt1=0, busy=0, err=0, wrt=0, done0=done1=0, wt_data=0.
REQ-030 Reset during XFER shall abandon the transfer; a subsequent done shall not produce any doneX.
REQ-031 After reset, the first simultaneous req0 and req1 shall grant requester 0 (because last=1).

Verification
REQ-032 Reset, then req0=req1=1 at cycle 0 -> gnt0=1 at cycle 2, gnt1=0; with req0 dropped after one transfer, gnt1=1 two cycles after gnt0 falls.
REQ-033 gnt0 high; wrt0 pulse with wt_data0=16'h2000 -> wrt=1 and wt_data=16'h2000 in the same cycle; done pulse -> done0=1, done1=0.
REQ-034 gnt0 high; wrt1 pulse with wt_data1=16'h7FFF -> wrt=0 and wt_data=16'h0000; state stays OWN.
REQ-035 TIMEOUT=8; req1 held, no wrt1 -> after 8 OWN cycles gnt1 falls and err pulses once; with req0=req1=1 next, gnt0 wins.
REQ-036 req0 dropped mid-XFER -> gnt0 stays high until done; done0 pulses; gnt0 falls the cycle after the FSM returns to OWN.
REQ-037 rst_n asserted mid-XFER, then done pulses -> done0=done1=0, gnt0=gnt1=0, busy=0.
